// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among num_req_p requesters: round-robin grant into
// an operand stage, then a response stage returned under valid/yumi back-pressure.
module alu_share_arbiter #(
    parameter  int num_req_p   = 4,
    localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic [num_req_p-1:0]      req_v_i,
    input  logic [num_req_p*32-1:0]   req_rs1_i,
    input  logic [num_req_p*32-1:0]   req_rs2_i,
    input  logic [num_req_p*32-1:0]   req_pc_plus4_i,
    input  logic [num_req_p*32-1:0]   req_op_i,
    output logic [num_req_p-1:0]      req_yumi_o,

    output logic [31:0]               alu_rs1_o,
    output logic [31:0]               alu_rs2_o,
    output logic [31:0]               alu_pc_plus4_o,
    output logic [31:0]               alu_op_o,
    input  logic [31:0]               alu_result_i,
    input  logic                      alu_jump_now_i,

    output logic                      resp_v_o,
    output logic [id_width_lp-1:0]    resp_id_o,
    output logic [31:0]               resp_result_o,
    output logic                      resp_jump_now_o,
    input  logic                      resp_yumi_i
);

    logic [31:0] rs1_arr [num_req_p];
    logic [31:0] rs2_arr [num_req_p];
    logic [31:0] pc4_arr [num_req_p];
    logic [31:0] op_arr  [num_req_p];

    for (genvar k = 0; k < num_req_p; k++) begin : g_unpack
        assign rs1_arr[k] = req_rs1_i[32*k +: 32];
        assign rs2_arr[k] = req_rs2_i[32*k +: 32];
        assign pc4_arr[k] = req_pc_plus4_i[32*k +: 32];
        assign op_arr[k]  = req_op_i[32*k +: 32];
    end

    logic                   v1_q, v1_d;
    logic [id_width_lp-1:0] id1_q, id1_d;
    logic [31:0]            rs1_q, rs1_d;
    logic [31:0]            rs2_q, rs2_d;
    logic [31:0]            pc4_q, pc4_d;
    logic [31:0]            op_q, op_d;
    logic                   v2_q, v2_d;
    logic [id_width_lp-1:0] id2_q, id2_d;
    logic [31:0]            result_q, result_d;
    logic                   jump_q, jump_d;
    logic [id_width_lp-1:0] last_q, last_d;

    logic                   s2_ready;
    logic                   s1_adv;
    logic                   s1_ready;
    logic                   grant_v;
    logic [id_width_lp-1:0] grant_id;
    logic [id_width_lp-1:0] cand;

    assign s2_ready = ~v2_q | resp_yumi_i;
    assign s1_adv   = v1_q & s2_ready;
    assign s1_ready = ~v1_q | s1_adv;

    // Search starts just past the last winner; nothing is accepted while in reset.
    always_comb begin
        grant_v    = 1'b0;
        grant_id   = '0;
        cand       = '0;
        req_yumi_o = '0;
        for (int i = 1; i <= num_req_p; i++) begin
            cand = id_width_lp'((int'(last_q) + i) % num_req_p);
            if (!grant_v && req_v_i[cand]) begin
                grant_v  = 1'b1;
                grant_id = cand;
            end
        end
        if (reset_i || !s1_ready) begin
            grant_v = 1'b0;
        end
        if (grant_v) begin
            req_yumi_o[grant_id] = 1'b1;
        end
    end

    always_comb begin
        v1_d     = v1_q;
        id1_d    = id1_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        pc4_d    = pc4_q;
        op_d     = op_q;
        v2_d     = v2_q;
        id2_d    = id2_q;
        result_d = result_q;
        jump_d   = jump_q;
        last_d   = last_q;

        if (s1_adv) begin
            v1_d = 1'b0;
        end
        if (grant_v) begin
            v1_d   = 1'b1;
            id1_d  = grant_id;
            rs1_d  = rs1_arr[grant_id];
            rs2_d  = rs2_arr[grant_id];
            pc4_d  = pc4_arr[grant_id];
            op_d   = op_arr[grant_id];
            last_d = grant_id;
        end

        if (s1_adv) begin
            v2_d     = 1'b1;
            id2_d    = id1_q;
            result_d = alu_result_i;
            jump_d   = alu_jump_now_i;
        end else if (resp_yumi_i) begin
            v2_d = 1'b0;
        end
    end

    // Pointer resets to the top index so requester 0 is first in line.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v1_q     <= 1'b0;
            id1_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            pc4_q    <= '0;
            op_q     <= '0;
            v2_q     <= 1'b0;
            id2_q    <= '0;
            result_q <= '0;
            jump_q   <= 1'b0;
            last_q   <= id_width_lp'(num_req_p - 1);
        end else begin
            v1_q     <= v1_d;
            id1_q    <= id1_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            pc4_q    <= pc4_d;
            op_q     <= op_d;
            v2_q     <= v2_d;
            id2_q    <= id2_d;
            result_q <= result_d;
            jump_q   <= jump_d;
            last_q   <= last_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (v2_q || !resp_yumi_i);
            assert ($onehot0(req_yumi_o));
        end
    end

    assign alu_rs1_o       = rs1_q;
    assign alu_rs2_o       = rs2_q;
    assign alu_pc_plus4_o  = pc4_q;
    assign alu_op_o        = op_q;

    assign resp_v_o        = v2_q;
    assign resp_id_o       = id2_q;
    assign resp_result_o   = result_q;
    assign resp_jump_now_o = jump_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios followed by random
// traffic, scored against a transaction-level queue model of the shared pipeline.
module tb_alu_share_arbiter;

   localparam int N = 4;

   localparam logic [31:0] OP_ADD  = 32'h0000_0033;
   localparam logic [31:0] OP_SUB  = 32'h4000_0033;
   localparam logic [31:0] OP_BLT  = 32'h0000_4063;
   localparam logic [31:0] OP_BLTU = 32'h0000_6063;
   localparam logic [31:0] OP_JAL  = 32'h0000_006F;

   logic            clk = 1'b0;
   logic            reset_i;
   logic [N-1:0]    req_v_i;
   logic [N*32-1:0] req_rs1_i;
   logic [N*32-1:0] req_rs2_i;
   logic [N*32-1:0] req_pc_plus4_i;
   logic [N*32-1:0] req_op_i;
   logic [N-1:0]    req_yumi_o;
   logic [31:0]     alu_rs1_o;
   logic [31:0]     alu_rs2_o;
   logic [31:0]     alu_pc_plus4_o;
   logic [31:0]     alu_op_o;
   logic [31:0]     alu_result_i;
   logic            alu_jump_now_i;
   logic            resp_v_o;
   logic [1:0]      resp_id_o;
   logic [31:0]     resp_result_o;
   logic            resp_jump_now_o;
   logic            resp_yumi_i;

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   alu_share_arbiter #(.num_req_p(N)) dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .req_v_i         (req_v_i),
      .req_rs1_i       (req_rs1_i),
      .req_rs2_i       (req_rs2_i),
      .req_pc_plus4_i  (req_pc_plus4_i),
      .req_op_i        (req_op_i),
      .req_yumi_o      (req_yumi_o),
      .alu_rs1_o       (alu_rs1_o),
      .alu_rs2_o       (alu_rs2_o),
      .alu_pc_plus4_o  (alu_pc_plus4_o),
      .alu_op_o        (alu_op_o),
      .alu_result_i    (alu_result_i),
      .alu_jump_now_i  (alu_jump_now_i),
      .resp_v_o        (resp_v_o),
      .resp_id_o       (resp_id_o),
      .resp_result_o   (resp_result_o),
      .resp_jump_now_o (resp_jump_now_o),
      .resp_yumi_i     (resp_yumi_i)
   );

   // A small stand-in for the shared ALU: returns {jump, result}; unknown ops give 0
   function automatic logic [32:0] aluEval(input logic [31:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] pc4);
      logic [32:0] r;
      r = 33'd0;
      case (op)
         OP_ADD:  r = {1'b0, a + b};
         OP_SUB:  r = {1'b0, a - b};
         OP_BLT:  r = {($signed(a) < $signed(b)), 32'd0};
         OP_BLTU: r = {(a < b), 32'd0};
         OP_JAL:  r = {1'b1, pc4};
         default: r = 33'd0;
      endcase
      return r;
   endfunction

   // The environment ALU reacts combinationally to the registered operands
   logic [32:0] aluOut;
   always_comb begin
      aluOut = aluEval(alu_op_o, alu_rs1_o, alu_rs2_o, alu_pc_plus4_o);
   end
   assign alu_result_i   = aluOut[31:0];
   assign alu_jump_now_i = aluOut[32];

   // Reference model: in-flight operations in issue order, each tagged with its grant cycle
   typedef struct {
      int          id;
      logic [31:0] result;
      logic        jump;
      int          grantCycle;
   } inflight_t;

   inflight_t   pipeQ[$];
   int          lastG;
   int          cycle;

   // Requester-side state: each holds its operation until it is accepted
   bit          pendV [N];
   bit          refill[N];
   logic [31:0] pRs1  [N];
   logic [31:0] pRs2  [N];
   logic [31:0] pPc4  [N];
   logic [31:0] pOp   [N];

   int          vectors;
   int          miscompares;
   int          yumiSeen;
   logic [N-1:0] lastYumiObs;

   // Every comparison goes through here so the counters stay honest
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic setOp(input int k, input logic [31:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      pOp[k]   = op;
      pRs1[k]  = a;
      pRs2[k]  = b;
      pPc4[k]  = $urandom;
      pendV[k] = 1'b1;
   endtask

   task automatic newRandomOp(input int k);
      logic [31:0] op;
      case ($urandom_range(0, 5))
         0:       op = OP_ADD;
         1:       op = OP_SUB;
         2:       op = OP_BLT;
         3:       op = OP_BLTU;
         4:       op = OP_JAL;
         default: op = $urandom;
      endcase
      setOp(k, op, $urandom, $urandom);
   endtask

   // Drive requester and consumer inputs for the current cycle
   task automatic applyStimulus(input bit takeResp, input bit rst);
      reset_i     = rst;
      resp_yumi_i = takeResp;
      for (int k = 0; k < N; k++) begin
         req_v_i[k]                 = pendV[k];
         req_rs1_i[32*k +: 32]      = pRs1[k];
         req_rs2_i[32*k +: 32]      = pRs2[k];
         req_pc_plus4_i[32*k +: 32] = pPc4[k];
         req_op_i[32*k +: 32]       = pOp[k];
      end
   endtask

   // One clock cycle: drive, compare against the model, then advance the model over the edge
   task automatic stepCycle(input bit yumiWant, input bit rst);
      bit          visible;
      bit          takeResp;
      bit          canGrant;
      int          winner;
      int          c;
      logic [32:0] r;
      logic [31:0] expYumi;
      inflight_t   e;

      visible  = (pipeQ.size() > 0) && (pipeQ[0].grantCycle <= cycle - 2);
      takeResp = yumiWant && visible && !rst;
      applyStimulus(takeResp, rst);
      #1;

      canGrant = !rst && ((pipeQ.size() < 2) || takeResp);
      winner   = -1;
      if (canGrant) begin
         for (int i = 1; i <= N; i++) begin
            c = (lastG + i) % N;
            if (winner < 0 && pendV[c]) winner = c;
         end
      end
      expYumi = (winner >= 0) ? (32'd1 << winner) : 32'd0;

      lastYumiObs = req_yumi_o;
      if (req_yumi_o != '0) yumiSeen++;

      checkOutput("req_yumi", {28'd0, req_yumi_o}, expYumi);
      checkOutput("resp_v", {31'd0, resp_v_o}, {31'd0, visible});
      if (visible) begin
         checkOutput("resp_id", {30'd0, resp_id_o}, 32'(pipeQ[0].id));
         checkOutput("resp_result", resp_result_o, pipeQ[0].result);
         checkOutput("resp_jump", {31'd0, resp_jump_now_o}, {31'd0, pipeQ[0].jump});
      end

      if (rst) begin
         pipeQ.delete();
         lastG = N - 1;
      end else begin
         if (takeResp) void'(pipeQ.pop_front());
         if (winner >= 0) begin
            r            = aluEval(pOp[winner], pRs1[winner], pRs2[winner], pPc4[winner]);
            e.id         = winner;
            e.result     = r[31:0];
            e.jump       = r[32];
            e.grantCycle = cycle;
            pipeQ.push_back(e);
            lastG         = winner;
            pendV[winner] = refill[winner];
         end
      end

      @(posedge clk);
      cycle++;
      @(negedge clk);
   endtask

   task automatic clearRequesters();
      for (int k = 0; k < N; k++) begin
         pendV[k]  = 1'b0;
         refill[k] = 1'b0;
         pRs1[k]   = '0;
         pRs2[k]   = '0;
         pPc4[k]   = '0;
         pOp[k]    = '0;
      end
   endtask

   // Directed scenarios, then random traffic with occasional resets
   initial begin
      vectors     = 0;
      miscompares = 0;
      yumiSeen    = 0;
      cycle       = 0;
      lastG       = N - 1;
      clearRequesters();
      applyStimulus(1'b0, 1'b1);

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("rst_resp_v", {31'd0, resp_v_o}, 32'd0);
      checkOutput("rst_req_yumi", {28'd0, req_yumi_o}, 32'd0);
      checkOutput("rst_alu_op", alu_op_o, 32'd0);
      checkOutput("rst_alu_rs1", alu_rs1_o, 32'd0);
      checkOutput("rst_resp_result", resp_result_o, 32'd0);
      @(negedge clk);

      // All four requesters issue ADD k+10 continuously with the consumer always taking
      for (int k = 0; k < N; k++) begin
         setOp(k, OP_ADD, 32'(k), 32'd10);
         refill[k] = 1'b1;
      end
      for (int s = 0; s < 8; s++) begin
         stepCycle(1'b1, 1'b0);
         if (s >= 1) begin
            checkOutput("rr_id", {30'd0, resp_id_o}, 32'((s - 1) % N));
            checkOutput("rr_result", resp_result_o, 32'(10 + ((s - 1) % N)));
         end
      end
      clearRequesters();
      repeat (3) stepCycle(1'b1, 1'b0);

      // Lone requester 2 with a SUB that goes negative
      setOp(2, OP_SUB, 32'd5, 32'd7);
      stepCycle(1'b1, 1'b0);
      checkOutput("sub_yumi", {28'd0, lastYumiObs}, 32'b0100);
      stepCycle(1'b1, 1'b0);
      checkOutput("sub_resp_v", {31'd0, resp_v_o}, 32'd1);
      checkOutput("sub_id", {30'd0, resp_id_o}, 32'd2);
      checkOutput("sub_result", resp_result_o, 32'hFFFF_FFFE);
      stepCycle(1'b1, 1'b0);

      // Signed versus unsigned less-than on the same operands
      setOp(1, OP_BLT, 32'hFFFF_FFFF, 32'd1);
      repeat (2) stepCycle(1'b1, 1'b0);
      checkOutput("blt_jump", {31'd0, resp_jump_now_o}, 32'd1);
      stepCycle(1'b1, 1'b0);
      setOp(1, OP_BLTU, 32'hFFFF_FFFF, 32'd1);
      repeat (2) stepCycle(1'b1, 1'b0);
      checkOutput("bltu_jump", {31'd0, resp_jump_now_o}, 32'd0);
      stepCycle(1'b1, 1'b0);

      // Consumer stalls for five cycles with everyone asking, then releases
      for (int k = 0; k < N; k++) begin
         setOp(k, OP_ADD, $urandom, $urandom);
         refill[k] = 1'b1;
      end
      yumiSeen = 0;
      repeat (5) stepCycle(1'b0, 1'b0);
      checkOutput("stall_grants", 32'(yumiSeen), 32'd2);
      stepCycle(1'b1, 1'b0);
      checkOutput("release_grant", {31'd0, (lastYumiObs != '0)}, 32'd1);
      repeat (5) stepCycle(1'b1, 1'b0);

      // Reset with both stages full; requester 0 must win first afterwards
      stepCycle(1'b0, 1'b1);
      for (int k = 0; k < N; k++) pendV[k] = 1'b0;
      stepCycle(1'b1, 1'b0);
      for (int k = 0; k < N; k++) pendV[k] = 1'b1;
      stepCycle(1'b1, 1'b0);
      checkOutput("post_rst_first", {28'd0, lastYumiObs}, 32'b0001);
      clearRequesters();
      repeat (3) stepCycle(1'b1, 1'b0);

      // Only requesters 1 and 3 active right after reset: 1, 3, then wrap back to 1
      stepCycle(1'b0, 1'b1);
      setOp(1, OP_ADD, 32'd1, 32'd1);
      setOp(3, OP_ADD, 32'd3, 32'd3);
      refill[1] = 1'b1;
      refill[3] = 1'b1;
      stepCycle(1'b1, 1'b0);
      checkOutput("skip_g1", {28'd0, lastYumiObs}, 32'b0010);
      stepCycle(1'b1, 1'b0);
      checkOutput("skip_g3", {28'd0, lastYumiObs}, 32'b1000);
      stepCycle(1'b1, 1'b0);
      checkOutput("skip_wrap", {28'd0, lastYumiObs}, 32'b0010);
      clearRequesters();
      repeat (3) stepCycle(1'b1, 1'b0);

      // Random traffic: bursty requesters, a mostly-willing consumer, rare resets
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < N; k++) begin
            if (!pendV[k] && ($urandom_range(0, 1) == 1)) newRandomOp(k);
         end
         stepCycle($urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
      end
      for (int k = 0; k < N; k++) pendV[k] = 1'b0;
      repeat (4) stepCycle(1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
